// File: rtl/i2s_tx_scheduler_pkg.sv
// Shared definitions for the I2S transmit scheduler: width helper, default sample width, FSM states.
package i2s_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 24;

    localparam logic [1:0] S_WAIT_RISE = 2'd0;
    localparam logic [1:0] S_COMMIT    = 2'd1;
    localparam logic [1:0] S_WAIT_FALL = 2'd2;

    // Ceiling log2; returns the index width needed for v entries.
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/i2s_tx_scheduler_if.sv
// Source handshake and i2s_master transmit-side signals shared by the scheduler and its neighbours.
interface i2s_tx_scheduler_if #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned DATA_WIDTH = 24
);
    logic [N_SRC-1:0]            src_valid;
    logic [N_SRC-1:0]            src_ready;
    logic [N_SRC*DATA_WIDTH-1:0] src_left;
    logic [N_SRC*DATA_WIDTH-1:0] src_right;
    logic                        ws;
    logic [DATA_WIDTH-1:0]       data_send_left;
    logic [DATA_WIDTH-1:0]       data_send_right;

    modport master (
        input  src_valid, src_left, src_right, ws,
        output src_ready, data_send_left, data_send_right
    );

    modport slave (
        output src_valid, src_left, src_right, ws,
        input  src_ready, data_send_left, data_send_right
    );
endinterface

// File: rtl/i2s_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping to index 0.
module rr_arbiter
    import i2s_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = log2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    localparam int unsigned N2 = 2 * N;

    logic [N2-1:0] req_dbl;
    logic [N2-1:0] keep_mask;

    // Lower copy is masked below ptr so the upper copy supplies the wrap-around.
    assign keep_mask = ~((N2'(1) << ptr) - N2'(1));
    assign req_dbl   = {req, req} & keep_mask;

    always_comb begin
        logic          found;
        logic [IW-1:0] k;
        found      = 1'b0;
        k          = '0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = |req;
        for (int unsigned i = 0; i < N2; i++) begin
            if (!found && req_dbl[i]) begin
                found         = 1'b1;
                k             = IW'(i % N);
                gnt_idx       = k;
                gnt_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_scheduler.sv
// Per-frame round-robin source selection feeding an I2S master with matched L/R pairs.
// Build option I2S_TX_HOLD_LAST_EN: a no-grant frame repeats the last sample instead of sending zeros.
module i2s_tx_scheduler
    import i2s_pkg::*;
#(
    parameter  int unsigned N_SRC      = 4,
    parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int unsigned CNT_WIDTH  = 16,
    localparam int unsigned IW         = log2(N_SRC)
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 enable,
    input  logic [N_SRC-1:0]     src_mask,
    i2s_tx_scheduler_if.master   bus,
    output logic [IW-1:0]        grant_idx,
    output logic                 grant_valid,
    output logic                 frame_tick,
    output logic                 underrun_pulse,
    output logic [CNT_WIDTH-1:0] underrun_count
);
    logic [1:0]            state_q, state_d;
    logic                  ws_q;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] staged_q, staged_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  gv_q, gv_d;
    logic                  tick_q, tick_d;
    logic                  und_q, und_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [N_SRC-1:0]      ready_c;

    logic                  ws_rise, ws_fall;
    logic [N_SRC-1:0]      eligible;
    logic [N_SRC-1:0]      gnt_onehot;
    logic [IW-1:0]         gnt_idx;
    logic                  gnt_any;

    assign ws_rise  = bus.ws & ~ws_q;
    assign ws_fall  = ~bus.ws & ws_q;
    assign eligible = bus.src_valid & src_mask & {N_SRC{enable}};

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req        (eligible),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= S_WAIT_RISE;
            ws_q     <= 1'b0;
            ptr_q    <= '0;
            left_q   <= '0;
            staged_q <= '0;
            right_q  <= '0;
            idx_q    <= '0;
            gv_q     <= 1'b0;
            tick_q   <= 1'b0;
            und_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ws_q     <= bus.ws;
            ptr_q    <= ptr_d;
            left_q   <= left_d;
            staged_q <= staged_d;
            right_q  <= right_d;
            idx_q    <= idx_d;
            gv_q     <= gv_d;
            tick_q   <= tick_d;
            und_q    <= und_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        left_d   = left_q;
        staged_d = staged_q;
        right_d  = right_q;
        idx_d    = idx_q;
        gv_d     = gv_q;
        tick_d   = 1'b0;
        und_d    = 1'b0;
        cnt_d    = cnt_q;
        ready_c  = '0;
        case (state_q)
            S_WAIT_RISE: begin
                if (ws_rise) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d = S_WAIT_FALL;
                tick_d  = 1'b1;
                if (gnt_any) begin
                    ready_c  = gnt_onehot;
                    left_d   = bus.src_left[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    staged_d = bus.src_right[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    idx_d    = gnt_idx;
                    gv_d     = 1'b1;
                    ptr_d    = (gnt_idx == IW'(N_SRC - 1)) ? '0 : IW'(gnt_idx + 1'b1);
                end else begin
                    gv_d = 1'b0;
`ifndef I2S_TX_HOLD_LAST_EN
                    left_d   = '0;
                    staged_d = '0;
`endif
                    if (enable) begin
                        und_d = 1'b1;
                        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = CNT_WIDTH'(cnt_q + 1'b1);
                    end
                end
            end
            S_WAIT_FALL: begin
                // Right word follows its left partner so the master reloads a matched pair.
                if (ws_fall) begin
                    state_d = S_WAIT_RISE;
                    right_d = staged_q;
                end
            end
            default: state_d = S_WAIT_RISE;
        endcase
    end

    assign bus.src_ready       = ready_c;
    assign bus.data_send_left  = left_q;
    assign bus.data_send_right = right_q;
    assign grant_idx           = idx_q;
    assign grant_valid         = gv_q;
    assign frame_tick          = tick_q;
    assign underrun_pulse      = und_q;
    assign underrun_count      = cnt_q;

endmodule
